bp_fe_gshare_pht: RTL and testbench

Gshare pattern history table for the front end. It hashes the fetch PC with the 12-bit global history register value and returns a registered taken/not-taken prediction. That prediction is the `branch_output` the GHR shifts in. On branch resolution it updates the indexed 2-bit saturating counter. After reset, a sweep state machine initialises every entry before lookups are accepted.

---
 rtl/bp_fe_gshare_pkg.sv | 26 ++
 rtl/bp_fe_gshare_pht_mem.sv | 31 +++
 rtl/bp_fe_gshare_pht.sv | 142 ++++++++++++++
 tb/tb_bp_fe_gshare_pht.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_gshare_pkg.sv
// Shared types, defaults and the 2-bit saturating counter update for the gshare PHT.
package bp_fe_gshare_pkg;

    localparam int BP_IDX_W = 12;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_CTR_INIT = 2'b01;

    typedef enum logic {
        E_INIT  = 1'b0,
        E_READY = 1'b1
    } bp_pht_state_e;

    // Saturates at both ends instead of wrapping.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_fe_gshare_pht_mem.sv
// 2^IDX_W x 2-bit counter storage: one synchronous read port, one write port,
// read-old-data on same-address collision, no reset so it maps onto block RAM.
module bp_fe_pht_mem
    import bp_fe_gshare_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  bp_ctr_t          i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output bp_ctr_t          o_rdata
);

    bp_ctr_t r_mem [2**IDX_W];
    bp_ctr_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bp_fe_gshare_pht.sv
// Gshare pattern history table: PC^GHR hash, registered prediction, counter update.
// Define BP_FE_GSHARE_BYPASS_EN to forward a same-cycle same-index update into the lookup.
module bp_fe_gshare_pht
    import bp_fe_gshare_pkg::*;
#(
    parameter int      PC_W     = 39,
    parameter int      IDX_W    = BP_IDX_W,
    parameter bp_ctr_t CTR_INIT = BP_CTR_INIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_v,
    input  logic [PC_W-1:0]  lookup_pc,
    input  logic [IDX_W-1:0] global_history,
    output logic             lookup_ready,
    output logic             pred_v,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    output logic [1:0]       pred_ctr,
    input  logic             upd_v,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [1:0]       upd_ctr,
    input  logic             upd_taken
);

    bp_pht_state_e    r_state;
    bp_pht_state_e    w_state_nxt;
    logic [IDX_W-1:0] r_sweep_addr;

    logic             w_lookup_acc;
    logic             w_upd_acc;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_pc;

    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    bp_ctr_t          w_wdata;
    bp_ctr_t          w_rdata;
    bp_ctr_t          w_ctr;

    logic             r_pred_v;
    logic             r_pred_loaded;
    logic [IDX_W-1:0] r_pred_idx;

    assign w_lookup_acc = lookup_v && (r_state == E_READY);
    assign w_upd_acc    = upd_v && (r_state == E_READY);
    assign w_idx        = lookup_pc[IDX_W+1:2] ^ global_history;
    assign w_unused_pc  = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= E_INIT;
            r_sweep_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == E_INIT) begin
                r_sweep_addr <= r_sweep_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            E_INIT:  if (r_sweep_addr == '1) w_state_nxt = E_READY;
            E_READY: w_state_nxt = E_READY;
            default: w_state_nxt = E_INIT;
        endcase
    end

    // The sweep owns the write port during INIT; updates are simply dropped then.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = upd_idx;
        w_wdata = bp_ctr_next(upd_ctr, upd_taken);
        if (r_state == E_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_sweep_addr;
            w_wdata = CTR_INIT;
        end else if (w_upd_acc) begin
            w_we = 1'b1;
        end
    end

    bp_fe_pht_mem #(
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_lookup_acc),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // ---- prediction stage: registered alongside the RAM read ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_v      <= 1'b0;
            r_pred_loaded <= 1'b0;
            r_pred_idx    <= '0;
        end else begin
            r_pred_v <= w_lookup_acc;
            if (w_lookup_acc) begin
                r_pred_loaded <= 1'b1;
                r_pred_idx    <= w_idx;
            end
        end
    end

`ifdef BP_FE_GSHARE_BYPASS_EN
    logic    r_byp;
    bp_ctr_t r_byp_ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp <= 1'b0;
        end else if (w_lookup_acc) begin
            r_byp <= w_upd_acc && (upd_idx == w_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (w_lookup_acc) begin
            r_byp_ctr <= bp_ctr_next(upd_ctr, upd_taken);
        end
    end

    assign w_ctr = r_byp ? r_byp_ctr : w_rdata;
`else
    assign w_ctr = w_rdata;
`endif

    // The RAM read register has no reset, so mask it until the first lookup after reset.
    assign pred_ctr     = r_pred_loaded ? w_ctr : 2'b00;
    assign pred_taken   = pred_ctr[1];
    assign pred_v       = r_pred_v;
    assign pred_idx     = r_pred_idx;
    assign lookup_ready = (r_state == E_READY);

endmodule

// File: tb/tb_bp_fe_gshare_pht.sv
// Directed bench for bp_fe_gshare_pht: reset sweep, hash, saturation, collision, re-reset.
module tb_bp_fe_gshare_pht;

    localparam int PC_W  = 39;
    localparam int IDX_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lookup_v = 1'b0;
    logic [PC_W-1:0]  lookup_pc = '0;
    logic [IDX_W-1:0] global_history = '0;
    logic             lookup_ready;
    logic             pred_v;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [1:0]       pred_ctr;
    logic             upd_v = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic [1:0]       upd_ctr = '0;
    logic             upd_taken = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bp_fe_gshare_pht #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lookup_v       (lookup_v),
        .lookup_pc      (lookup_pc),
        .global_history (global_history),
        .lookup_ready   (lookup_ready),
        .pred_v         (pred_v),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .pred_ctr       (pred_ctr),
        .upd_v          (upd_v),
        .upd_idx        (upd_idx),
        .upd_ctr        (upd_ctr),
        .upd_taken      (upd_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge right after rst_n releases; counts edges until lookup_ready.
    // Optionally fires a lookup and an update (idx 9, ctr 11, taken) mid-sweep.
    task automatic sweep_count(input bit poke, output int cnt, output int bad);
        cnt = 0;
        bad = 0;
        while (lookup_ready !== 1'b1 && cnt < 5000) begin
            if (poke && cnt == 10) begin
                lookup_v       = 1'b1;
                lookup_pc      = 39'(9 << 2);
                global_history = '0;
                upd_v          = 1'b1;
                upd_idx        = 12'd9;
                upd_ctr        = 2'b11;
                upd_taken      = 1'b1;
            end else begin
                lookup_v = 1'b0;
                upd_v    = 1'b0;
            end
            @(posedge clk);
            #1;
            cnt++;
            if (pred_v !== 1'b0) bad++;
            @(negedge clk);
        end
        lookup_v = 1'b0;
        upd_v    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single-cycle lookup; returns with outputs sampled #1 after the accepting edge.
    task automatic lookup(input logic [PC_W-1:0] pc, input logic [IDX_W-1:0] gh);
        @(negedge clk);
        lookup_v       = 1'b1;
        lookup_pc      = pc;
        global_history = gh;
        @(posedge clk);
        #1;
        lookup_v = 1'b0;
    endtask

    task automatic update(input logic [IDX_W-1:0] idx, input logic [1:0] ctr, input logic tk);
        @(negedge clk);
        upd_v     = 1'b1;
        upd_idx   = idx;
        upd_ctr   = ctr;
        upd_taken = tk;
        @(posedge clk);
        #1;
        upd_v = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;
        logic [1:0] c;
        logic [1:0] exp_up [4];
        logic [1:0] exp_dn [4];
        exp_up = '{2'd2, 2'd3, 2'd3, 2'd3};
        exp_dn = '{2'd2, 2'd1, 2'd0, 2'd0};

        #2;
        chk("rst_ready", 32'(lookup_ready), 32'd0);
        chk("rst_pred_v", 32'(pred_v), 32'd0);
        chk("rst_pred_idx", 32'(pred_idx), 32'd0);
        chk("rst_pred_ctr", 32'(pred_ctr), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);

        apply_reset();
        sweep_count(1'b1, cnt, bad);
        chk("init_len", 32'(cnt), 32'd4096);
        chk("init_no_pred", 32'(bad), 32'd0);

        lookup(39'(9 << 2), 12'h000);
        chk("idx9_pred_v", 32'(pred_v), 32'd1);
        chk("idx9_ctr", 32'(pred_ctr), 32'd1);
        chk("idx9_taken", 32'(pred_taken), 32'd0);

        lookup(39'h1000, 12'h3FF);
        chk("hash_pred_v", 32'(pred_v), 32'd1);
        chk("hash_idx", 32'(pred_idx), 32'h7FF);
        chk("hash_ctr", 32'(pred_ctr), 32'd1);
        @(posedge clk);
        #1;
        chk("hash_v_drop", 32'(pred_v), 32'd0);
        chk("hash_idx_hold", 32'(pred_idx), 32'h7FF);

        lookup(39'(5 << 2), 12'h000);
        c = pred_ctr;
        chk("sat_start", 32'(c), 32'd1);
        for (int i = 0; i < 4; i++) begin
            update(12'd5, c, 1'b1);
            lookup(39'(5 << 2), 12'h000);
            c = pred_ctr;
            chk($sformatf("sat_up%0d", i), 32'(c), 32'(exp_up[i]));
        end
        chk("sat_up_taken", 32'(pred_taken), 32'd1);
        for (int i = 0; i < 4; i++) begin
            update(12'd5, c, 1'b0);
            lookup(39'(5 << 2), 12'h000);
            c = pred_ctr;
            chk($sformatf("sat_dn%0d", i), 32'(c), 32'(exp_dn[i]));
        end

        // Same-cycle update and lookup to idx 7 (lookup via pc=0x1C ^ gh=0).
        @(negedge clk);
        upd_v          = 1'b1;
        upd_idx        = 12'd7;
        upd_ctr        = 2'b01;
        upd_taken      = 1'b1;
        lookup_v       = 1'b1;
        lookup_pc      = 39'h1C;
        global_history = 12'h000;
        @(posedge clk);
        #1;
        upd_v    = 1'b0;
        lookup_v = 1'b0;
`ifdef BP_FE_GSHARE_BYPASS_EN
        chk("coll_ctr", 32'(pred_ctr), 32'd2);
        chk("coll_taken", 32'(pred_taken), 32'd1);
`else
        chk("coll_ctr", 32'(pred_ctr), 32'd1);
        chk("coll_taken", 32'(pred_taken), 32'd0);
`endif
        chk("coll_idx", 32'(pred_idx), 32'd7);
        lookup(39'h1C, 12'h000);
        chk("coll_after", 32'(pred_ctr), 32'd2);

        // Same cycle, different indices: both accepted independently.
        @(negedge clk);
        upd_v          = 1'b1;
        upd_idx        = 12'd20;
        upd_ctr        = 2'b01;
        upd_taken      = 1'b1;
        lookup_v       = 1'b1;
        lookup_pc      = 39'(21 << 2);
        global_history = 12'h000;
        @(posedge clk);
        #1;
        upd_v    = 1'b0;
        lookup_v = 1'b0;
        chk("dual_lookup21", 32'(pred_ctr), 32'd1);
        lookup(39'(20 << 2), 12'h000);
        chk("dual_upd20", 32'(pred_ctr), 32'd2);

        // Asynchronous reset while a prediction is being presented.
        lookup(39'(5 << 2), 12'h000);
        chk("ready_pred_v", 32'(pred_v), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_pred_v", 32'(pred_v), 32'd0);
        chk("areset_ready", 32'(lookup_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_count(1'b0, cnt, bad);
        chk("resweep_len", 32'(cnt), 32'd4096);

        // Reset again at sweep cycle 2000.
        apply_reset();
        repeat (2000) @(negedge clk);
        chk("mid_ready", 32'(lookup_ready), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep_count(1'b0, cnt, bad);
        chk("mid_resweep_len", 32'(cnt), 32'd4096);
        lookup(39'(5 << 2), 12'h000);
        chk("mid_idx5_init", 32'(pred_ctr), 32'd1);
        lookup(39'(7 << 2), 12'h000);
        chk("mid_idx7_init", 32'(pred_ctr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
